// File: rtl/siso_pkg.sv
// Shared types and sizing helpers for the SISO sequencer and its chain.
package siso_pkg;

    typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} siso_state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Counter must hold WIDTH+DEPTH so the last SHIFT index never wraps
    function automatic int CNT_W(input int width, input int depth);
        return $clog2(width + depth + 1);
    endfunction

endpackage

// File: rtl/siso_seq_ctrl_if.sv
// Parallel-side word handshake between the control logic and the SISO sequencer.
interface siso_seq_ctrl_if
    import siso_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, err
    );

endinterface

// File: rtl/siso_chain.sv
// DEPTH-stage serial-in/serial-out shift register; so is the registered last stage.
module siso_chain
    import siso_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic clk,
    input  logic clear,
    input  logic en,
    input  logic si,
    output logic so
);

    logic [DEPTH-1:0] stages;

    // Shift form keeps DEPTH=1 legal without a special case
    always_ff @(posedge clk) begin
        if (clear) begin
            stages <= '0;
        end else if (en) begin
            stages <= (stages << 1) | DEPTH'(si);
        end
    end

    assign so = stages[DEPTH-1];

endmodule

// File: rtl/siso_seq_ctrl.sv
// Sequencer: accepts a word, clears the chain, streams it LSB-first and
// compares the bits returned at the chain output against what was sent.
module siso_seq_ctrl
    import siso_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic           clk,
    input  logic           clear,
    siso_seq_ctrl_if.slave bus,
    input  logic           abort,
    output logic           busy,
    output logic           sr_clear,
    output logic           sr_en,
    output logic           sr_si,
    input  logic           sr_so
);

    localparam int            CW      = CNT_W(WIDTH, DEPTH);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(WIDTH + DEPTH - 1);

    siso_state_t      state_q;
    siso_state_t      state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] tx_sh;
    logic [WIDTH-1:0] rx_sh;
    logic [WIDTH-1:0] rx_data_q;
    logic [WIDTH-1:0] tx_cur;
    logic             err_q;
    logic             rx_valid;
    logic             tx_ready;
    logic             in_flight;

    assign tx_cur    = tx_sh >> cnt_q;
    assign in_flight = (state_q == CLR) || (state_q == SHIFT);

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Only abort/clear reach sr_clear and tx_ready combinationally; the rest is state-decoded
    always_comb begin
        state_d  = state_q;
        tx_ready = 1'b0;
        busy     = 1'b1;
        sr_en    = 1'b0;
        sr_si    = 1'b0;
        rx_valid = 1'b0;
        sr_clear = clear || (abort && in_flight);
        case (state_q)
            IDLE: begin
                busy     = 1'b0;
                tx_ready = !clear;
                if (bus.tx_valid) begin
                    state_d = CLR;
                end
            end
            CLR: begin
                sr_clear = 1'b1;
                state_d  = abort ? IDLE : SHIFT;
            end
            SHIFT: begin
                sr_en = 1'b1;
                if (cnt_q < WIDTH_C) begin
                    sr_si = tx_cur[0];
                end
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST_C) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rx_valid = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Returned bits enter at the top so the first one lands in bit 0 after WIDTH captures
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q     <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            rx_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.tx_valid) begin
                        tx_sh <= bus.tx_data;
                        cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    if (!abort) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q >= DEPTH_C) begin
                            rx_sh <= (rx_sh >> 1) | (WIDTH'(sr_so) << (WIDTH - 1));
                        end
                    end
                end
                DONE: begin
                    rx_data_q <= rx_sh;
                    err_q     <= (rx_sh != tx_sh);
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_ready = tx_ready;
    assign bus.rx_valid = rx_valid;
    assign bus.rx_data  = rx_data_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_siso_seq_ctrl.sv
// Directed bench for siso_seq_ctrl closed in loopback through siso_chain (WIDTH=8, DEPTH=4).
module tb_siso_seq_ctrl;

    logic clk;
    logic clear;
    logic abort;
    logic busy;
    logic sr_clear;
    logic sr_en;
    logic sr_si;
    logic sr_so;
    logic chain_so;
    logic inject;
    int   errors;
    int   checks;

    siso_seq_ctrl_if #(.WIDTH(8)) bus ();

    siso_seq_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
        .clk      (clk),
        .clear    (clear),
        .bus      (bus),
        .abort    (abort),
        .busy     (busy),
        .sr_clear (sr_clear),
        .sr_en    (sr_en),
        .sr_si    (sr_si),
        .sr_so    (sr_so)
    );

    siso_chain #(.DEPTH(4)) chain (
        .clk   (clk),
        .clear (sr_clear),
        .en    (sr_en),
        .si    (sr_si),
        .so    (chain_so)
    );

    // Fault injection flips the returned bit on the way back to the controller
    assign sr_so = chain_so ^ inject;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] word);
        bus.tx_data  = word;
        bus.tx_valid = 1'b1;
        cyc();
        bus.tx_valid = 1'b0;
    endtask

    // Cycle numbers count from the accept edge; returns in the IDLE cycle after DONE
    task automatic run_transfer(input logic [7:0] word, input int fault_k,
                                output int lat, output int en_cnt, output logic [11:0] si_bits);
        start(word);
        lat     = 1;
        en_cnt  = 0;
        si_bits = '0;
        while (!bus.rx_valid && lat < 40) begin
            inject = (lat == fault_k + 2);
            if (sr_en) begin
                if (en_cnt < 12) si_bits[en_cnt] = sr_si;
                en_cnt++;
            end
            cyc();
            lat++;
        end
        inject = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        clear = 1'b1;
        cyc();
        cyc();
        checks++;
        if (sr_clear !== 1'b1 || bus.tx_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_gating: sr_clear=%b tx_ready=%b, want 1 0", sr_clear, bus.tx_ready);
        end
        checks++;
        if ({bus.rx_data, bus.err, bus.rx_valid, busy, sr_en, sr_si} !== 13'b0) begin
            errors++;
            $display("[TB] FAIL reset_values: rx_data=%h err=%b rx_valid=%b busy=%b sr_en=%b sr_si=%b, want all 0",
                     bus.rx_data, bus.err, bus.rx_valid, busy, sr_en, sr_si);
        end
        clear = 1'b0;
        #1;
        checks++;
        if (bus.tx_ready !== 1'b1 || sr_clear !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: tx_ready=%b sr_clear=%b, want 1 0", bus.tx_ready, sr_clear);
        end
    endtask

    task automatic test_basic();
        int lat;
        int en_cnt;
        logic [11:0] si_bits;
        run_transfer(8'hA5, -1, lat, en_cnt, si_bits);
        checks++;
        if (lat !== 14) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d cycles, want 14", lat);
        end
        checks++;
        if (en_cnt !== 12) begin
            errors++;
            $display("[TB] FAIL basic_sr_en: got %0d cycles, want 12", en_cnt);
        end
        checks++;
        if (si_bits !== 12'h0A5) begin
            errors++;
            $display("[TB] FAIL basic_serial: got %h, want 0a5", si_bits);
        end
        checks++;
        if (bus.rx_data !== 8'hA5 || bus.err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_rx: rx_data=%h err=%b, want a5 0", bus.rx_data, bus.err);
        end
        checks++;
        if (bus.tx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_idle: tx_ready=%b busy=%b, want 1 0", bus.tx_ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        int t;
        int bad;
        bus.tx_data  = 8'h01;
        bus.tx_valid = 1'b1;
        cyc();
        t   = 1;
        bad = 0;
        while (!bus.tx_ready && t < 40) begin
            if (busy !== 1'b1) bad++;
            cyc();
            t++;
        end
        checks++;
        if (t !== 15 || bad !== 0) begin
            errors++;
            $display("[TB] FAIL b2b_spacing: second accept at %0d (busy gaps %0d), want 15 (0)", t, bad);
        end
        checks++;
        if (bus.rx_data !== 8'h01 || bus.err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_first: rx_data=%h err=%b, want 01 0", bus.rx_data, bus.err);
        end
        bus.tx_data = 8'h80;
        cyc();
        bus.tx_valid = 1'b0;
        t = 1;
        while (!bus.rx_valid && t < 40) begin
            cyc();
            t++;
        end
        cyc();
        checks++;
        if (t !== 14 || bus.rx_data !== 8'h80 || bus.err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_second: lat=%0d rx_data=%h err=%b, want 14 80 0", t, bus.rx_data, bus.err);
        end
    endtask

    task automatic test_fault();
        int lat;
        int en_cnt;
        logic [11:0] si_bits;
        run_transfer(8'h00, 6, lat, en_cnt, si_bits);
        checks++;
        if (bus.rx_data !== 8'h04 || bus.err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fault_rx: rx_data=%h err=%b, want 04 1", bus.rx_data, bus.err);
        end
        repeat (3) cyc();
        checks++;
        if (bus.err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fault_hold: err=%b, want 1", bus.err);
        end
    endtask

    task automatic test_abort();
        int rv;
        int lat;
        int en_cnt;
        logic [11:0] si_bits;
        start(8'hFF);
        repeat (6) cyc();
        abort = 1'b1;
        #1;
        checks++;
        if (sr_clear !== 1'b1 || sr_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_cycle: sr_clear=%b sr_en=%b, want 1 1", sr_clear, sr_en);
        end
        cyc();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus.tx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_idle: busy=%b tx_ready=%b, want 0 1", busy, bus.tx_ready);
        end
        rv = 0;
        repeat (20) begin
            if (bus.rx_valid) rv++;
            cyc();
        end
        checks++;
        if (rv !== 0 || bus.rx_data !== 8'h04 || bus.err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_retain: rx_valid pulses=%0d rx_data=%h err=%b, want 0 04 1",
                     rv, bus.rx_data, bus.err);
        end
        run_transfer(8'h3C, -1, lat, en_cnt, si_bits);
        checks++;
        if (lat !== 14 || bus.rx_data !== 8'h3C || bus.err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_next: lat=%0d rx_data=%h err=%b, want 14 3c 0", lat, bus.rx_data, bus.err);
        end
    endtask

    task automatic test_reset_mid();
        int rv;
        start(8'h5A);
        repeat (4) cyc();
        clear = 1'b1;
        #1;
        checks++;
        if (sr_clear !== 1'b1 || bus.tx_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_gating: sr_clear=%b tx_ready=%b, want 1 0", sr_clear, bus.tx_ready);
        end
        cyc();
        checks++;
        if ({bus.rx_data, bus.err, bus.rx_valid, busy, sr_en, sr_si} !== 13'b0) begin
            errors++;
            $display("[TB] FAIL midreset_values: rx_data=%h err=%b rx_valid=%b busy=%b sr_en=%b sr_si=%b, want all 0",
                     bus.rx_data, bus.err, bus.rx_valid, busy, sr_en, sr_si);
        end
        clear = 1'b0;
        #1;
        rv = 0;
        checks++;
        if (bus.tx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_ready: tx_ready=%b, want 1", bus.tx_ready);
        end
        repeat (20) begin
            if (bus.rx_valid) rv++;
            cyc();
        end
        checks++;
        if (rv !== 0 || bus.rx_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midreset_silent: rx_valid pulses=%0d rx_data=%h, want 0 00", rv, bus.rx_data);
        end
    endtask

    task automatic test_priority();
        int lat;
        int en_cnt;
        int t;
        logic [11:0] si_bits;
        run_transfer(8'hC3, -1, lat, en_cnt, si_bits);
        checks++;
        if (bus.rx_data !== 8'hC3) begin
            errors++;
            $display("[TB] FAIL prio_setup: rx_data=%h, want c3", bus.rx_data);
        end
        start(8'h96);
        clear = 1'b1;
        abort = 1'b1;
        cyc();
        clear = 1'b0;
        abort = 1'b0;
        #1;
        checks++;
        if (bus.rx_data !== 8'h00 || busy !== 1'b0 || bus.tx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL prio_clear_abort: rx_data=%h busy=%b tx_ready=%b, want 00 0 1",
                     bus.rx_data, busy, bus.tx_ready);
        end
        bus.tx_data  = 8'hD2;
        bus.tx_valid = 1'b1;
        cyc();
        t = 1;
        while (!bus.rx_valid && t < 40) begin
            cyc();
            t++;
        end
        checks++;
        if (t !== 14 || bus.tx_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prio_done_ready: lat=%0d tx_ready=%b, want 14 0", t, bus.tx_ready);
        end
        cyc();
        checks++;
        if (busy !== 1'b0 || bus.tx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL prio_done_noaccept: busy=%b tx_ready=%b, want 0 1", busy, bus.tx_ready);
        end
        cyc();
        bus.tx_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || sr_clear !== 1'b1) begin
            errors++;
            $display("[TB] FAIL prio_late_accept: busy=%b sr_clear=%b, want 1 1", busy, sr_clear);
        end
        t = 1;
        while (!bus.rx_valid && t < 40) begin
            cyc();
            t++;
        end
        cyc();
        checks++;
        if (bus.rx_data !== 8'hD2 || bus.err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prio_late_rx: rx_data=%h err=%b, want d2 0", bus.rx_data, bus.err);
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        clear        = 1'b1;
        abort        = 1'b0;
        inject       = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        test_reset();
        test_basic();
        test_back_to_back();
        test_fault();
        test_abort();
        test_reset_mid();
        test_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
